// File: rtl/fetch_controller.sv
// fetch_controller: instruction fetch front end for a synchronous instruction ROM.
// It issues sequential PCs, captures ROM responses into a 2-entry FIFO and offers
// them downstream with a valid/ready handshake. Redirects flush the pipeline.
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect
// targets into a HALT state (fault=1). When the macro is absent, the low target
// bits are cleared and the redirect proceeds normally.
module fetch_controller #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ADDR_SIZE = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        fault
);

    // ADDR_SIZE only documents the ROM reach; it must still name a bit of a 32-bit address.
    if (ADDR_SIZE < 2 || ADDR_SIZE > 31) begin : g_bad_addr_size
        $error("fetch_controller: ADDR_SIZE must be in 2..31");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_next_pc;
    logic [31:0] w_next_pc;
    logic        r_inflight;
    logic        w_inflight;
    logic [31:0] r_inflight_pc;
    logic [31:0] w_inflight_pc;
    logic [31:0] r_buf_inst [2];
    logic [31:0] r_buf_pc   [2];
    logic        r_head;
    logic [1:0]  r_count;
    logic        w_flush;
    logic        w_pop;
    logic        w_push;
    logic        w_misalign;
    logic [31:0] w_target;

    // Word-aligned redirect target; the low two bits never reach the ROM.
    assign w_target = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign w_misalign = (redirect_pc[1:0] != 2'b00);
    assign fault      = (r_state == HALT);
`else
    assign w_misalign = 1'b0;
    assign fault      = 1'b0;
`endif

    // A response is kept unless a redirect in the same cycle makes it stale.
    assign w_push   = r_inflight & ~w_flush;
    assign out_inst = r_buf_inst[r_head];
    assign out_pc   = r_buf_pc[r_head];

    // Next-state, issue decision, ROM address and downstream valid.
    always_comb begin
        w_state_next  = r_state;
        w_next_pc     = r_next_pc;
        w_inflight    = 1'b0;
        w_inflight_pc = r_inflight_pc;
        w_flush       = 1'b0;
        w_pop         = 1'b0;
        mem_addr      = r_next_pc;
        out_valid     = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_next = FETCH;
                if (redirect_valid) begin
                    w_next_pc = w_target;
                end
            end
            FETCH: begin
                if (redirect_valid) begin
                    w_flush = 1'b1;
                    if (w_misalign) begin
                        w_state_next = HALT;
                    end else begin
                        mem_addr = w_target;
                        if (fetch_en) begin
                            w_inflight    = 1'b1;
                            w_inflight_pc = w_target;
                            w_next_pc     = w_target + 32'd4;
                        end else begin
                            w_next_pc = w_target;
                        end
                    end
                end else begin
                    out_valid = (r_count != 2'd0);
                    w_pop     = out_valid & out_ready;
                    if (fetch_en &&
                        (({1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop}) < 3'd2)) begin
                        w_inflight    = 1'b1;
                        w_inflight_pc = r_next_pc;
                        w_next_pc     = r_next_pc + 32'd4;
                    end
                end
            end
            HALT: begin
                w_state_next = HALT;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State, PC and in-flight tracking registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_next_pc     <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= RESET_PC;
        end else begin
            r_state       <= w_state_next;
            r_next_pc     <= w_next_pc;
            r_inflight    <= w_inflight;
            r_inflight_pc <= w_inflight_pc;
        end
    end

    // Two-entry response FIFO; the write slot is head plus occupancy modulo 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_buf_inst[i] <= 32'h0;
                r_buf_pc[i]   <= RESET_PC;
            end
            r_head  <= 1'b0;
            r_count <= 2'd0;
        end else if (w_flush) begin
            r_head  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_buf_inst[r_head ^ r_count[0]] <= mem_inst;
                r_buf_pc[r_head ^ r_count[0]]   <= r_inflight_pc;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed testbench for fetch_controller. The ROM model returns word index
// (address >> 2) one cycle after the address is presented.
module tb_fetch_controller;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] mem_addr;
    logic [31:0] mem_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        fault;

    int total = 0;
    int bad   = 0;

    fetch_controller #(
        .RESET_PC (32'h0000_0000),
        .ADDR_SIZE(7)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .mem_addr      (mem_addr),
        .mem_inst      (mem_inst),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_inst      (out_inst),
        .out_pc        (out_pc),
        .fault         (fault)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous ROM: word[i] = i.
    always @(posedge clk) begin
        mem_inst <= mem_addr >> 2;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Advance one cycle; return at the following negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset with the given fetch_en/out_ready, release at a negedge; DUT is then in IDLE.
    task automatic applyStimulus(input logic en, input logic rdy);
        @(negedge clk);
        rst            = 1'b1;
        fetch_en       = en;
        out_ready      = rdy;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        fetch_en = 1'b1;
        out_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%0b exp=0", out_valid); end
        total++; if (out_inst !== 32'h0) begin bad++; $display("[TB] FAIL reset_inst got=%h exp=0", out_inst); end
        total++; if (out_pc !== 32'h0) begin bad++; $display("[TB] FAIL reset_pc got=%h exp=0", out_pc); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("[TB] FAIL reset_addr got=%h exp=0", mem_addr); end
        total++; if (fault !== 1'b0) begin bad++; $display("[TB] FAIL reset_fault got=%0b exp=0", fault); end
    endtask

    // Streaming at full rate: addresses 0,4,8,...; deliveries start two cycles after the first issue.
    task automatic test_stream();
        applyStimulus(1'b1, 1'b1);
        for (int k = 0; k < 7; k++) begin
            step();
            total++; if (mem_addr !== 32'(4 * k)) begin bad++; $display("[TB] FAIL stream_addr k=%0d got=%h exp=%h", k, mem_addr, 32'(4 * k)); end
            total++; if (out_valid !== (k >= 2)) begin bad++; $display("[TB] FAIL stream_valid k=%0d got=%0b exp=%0b", k, out_valid, (k >= 2)); end
            if (k >= 2) begin
                total++; if (out_pc !== 32'(4 * (k - 2))) begin bad++; $display("[TB] FAIL stream_pc k=%0d got=%h exp=%h", k, out_pc, 32'(4 * (k - 2))); end
                total++; if (out_inst !== 32'(k - 2)) begin bad++; $display("[TB] FAIL stream_inst k=%0d got=%h exp=%h", k, out_inst, 32'(k - 2)); end
            end
        end
    endtask

    // Backpressure: buffer fills with PCs 0 and 4, issue stalls at 8, then drains in order.
    task automatic test_backpressure();
        applyStimulus(1'b1, 1'b0);
        step();
        step();
        for (int k = 2; k <= 6; k++) begin
            step();
            if (k == 2) begin
                // first out_valid appears at k=2; it was checked from the k=2 sample below
            end
            total++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin bad++; $display("[TB] FAIL bp_hold k=%0d valid=%0b pc=%h exp valid=1 pc=0", k, out_valid, out_pc); end
            total++; if (mem_addr !== 32'h8) begin bad++; $display("[TB] FAIL bp_stall_addr k=%0d got=%h exp=8", k, mem_addr); end
        end
        out_ready = 1'b1;
        for (int k = 7; k <= 9; k++) begin
            step();
            total++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * (k - 6))) begin bad++; $display("[TB] FAIL bp_drain k=%0d valid=%0b pc=%h exp pc=%h", k, out_valid, out_pc, 32'(4 * (k - 6))); end
            total++; if (out_inst !== 32'(k - 6)) begin bad++; $display("[TB] FAIL bp_drain_inst k=%0d got=%h exp=%h", k, out_inst, 32'(k - 6)); end
        end
    endtask

    // Redirect to 0x40 with two buffered instructions: nothing stale is delivered.
    task automatic test_redirect();
        applyStimulus(1'b1, 1'b0);
        for (int k = 0; k <= 4; k++) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL redir_valid got=%0b exp=0", out_valid); end
        total++; if (mem_addr !== 32'h40) begin bad++; $display("[TB] FAIL redir_addr got=%h exp=40", mem_addr); end
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || mem_addr !== 32'h44) begin bad++; $display("[TB] FAIL redir_gap valid=%0b addr=%h exp valid=0 addr=44", out_valid, mem_addr); end
        for (int j = 0; j < 3; j++) begin
            step();
            total++; if (out_valid !== 1'b1 || out_pc !== 32'(32'h40 + 4 * j)) begin bad++; $display("[TB] FAIL redir_pc j=%0d valid=%0b pc=%h exp=%h", j, out_valid, out_pc, 32'(32'h40 + 4 * j)); end
            total++; if (out_inst !== 32'(32'h10 + j)) begin bad++; $display("[TB] FAIL redir_inst j=%0d got=%h exp=%h", j, out_inst, 32'(32'h10 + j)); end
        end
    endtask

    // Redirect near the top of the address space: PC wraps to zero.
    task automatic test_wrap();
        logic [31:0] expPc [3];
        expPc[0] = 32'hFFFF_FFF8;
        expPc[1] = 32'hFFFF_FFFC;
        expPc[2] = 32'h0000_0000;
        applyStimulus(1'b1, 1'b1);
        for (int k = 0; k <= 4; k++) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        #1;
        total++; if (mem_addr !== 32'hFFFF_FFF8 || out_valid !== 1'b0) begin bad++; $display("[TB] FAIL wrap_issue addr=%h valid=%0b", mem_addr, out_valid); end
        step();
        redirect_valid = 1'b0;
        #1;
        total++; if (mem_addr !== 32'hFFFF_FFFC) begin bad++; $display("[TB] FAIL wrap_addr got=%h exp=fffffffc", mem_addr); end
        for (int j = 0; j < 3; j++) begin
            step();
            total++; if (out_valid !== 1'b1 || out_pc !== expPc[j]) begin bad++; $display("[TB] FAIL wrap_pc j=%0d valid=%0b pc=%h exp=%h", j, out_valid, out_pc, expPc[j]); end
            total++; if (out_inst !== (expPc[j] >> 2)) begin bad++; $display("[TB] FAIL wrap_inst j=%0d got=%h exp=%h", j, out_inst, expPc[j] >> 2); end
        end
    endtask

    // Misaligned redirect to 0x42: trap into HALT with the macro, aligned to 0x40 without.
    task automatic test_misalign();
        applyStimulus(1'b1, 1'b0);
        for (int k = 0; k <= 4; k++) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mis_valid got=%0b exp=0", out_valid); end
`ifdef FETCH_MISALIGN_TRAP_EN
        step();
        redirect_pc = 32'h80;
        out_ready   = 1'b1;
        #1;
        total++; if (fault !== 1'b1) begin bad++; $display("[TB] FAIL mis_fault got=%0b exp=1", fault); end
        for (int j = 0; j < 3; j++) begin
            step();
            redirect_valid = 1'b0;
            total++; if (fault !== 1'b1 || out_valid !== 1'b0 || mem_addr !== 32'h8) begin bad++; $display("[TB] FAIL mis_halt j=%0d fault=%0b valid=%0b addr=%h", j, fault, out_valid, mem_addr); end
        end
        rst = 1'b1;
        #1;
        total++; if (fault !== 1'b0) begin bad++; $display("[TB] FAIL mis_clear got=%0b exp=0", fault); end
        @(negedge clk);
        rst = 1'b0;
`else
        total++; if (mem_addr !== 32'h40 || fault !== 1'b0) begin bad++; $display("[TB] FAIL mis_align addr=%h fault=%0b exp addr=40", mem_addr, fault); end
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        step();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h40) begin bad++; $display("[TB] FAIL mis_resume valid=%0b pc=%h exp=40", out_valid, out_pc); end
`endif
    endtask

    // fetch_en low: in-flight response still lands and drains, no new issue.
    task automatic test_fetch_en();
        applyStimulus(1'b1, 1'b1);
        step();
        step();
        fetch_en = 1'b0;
        step();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || mem_addr !== 32'h4) begin bad++; $display("[TB] FAIL fen_drain valid=%0b pc=%h addr=%h", out_valid, out_pc, mem_addr); end
        step();
        total++; if (out_valid !== 1'b0 || mem_addr !== 32'h4) begin bad++; $display("[TB] FAIL fen_idle valid=%0b addr=%h exp valid=0 addr=4", out_valid, mem_addr); end
        fetch_en = 1'b1;
    endtask

    // Asynchronous reset between edges mid-stream, then a clean restart.
    task automatic test_async_reset();
        applyStimulus(1'b1, 1'b1);
        for (int k = 0; k <= 5; k++) step();
        #3;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== 32'h0) begin bad++; $display("[TB] FAIL arst_out valid=%0b pc=%h inst=%h", out_valid, out_pc, out_inst); end
        total++; if (mem_addr !== 32'h0 || fault !== 1'b0) begin bad++; $display("[TB] FAIL arst_addr addr=%h fault=%0b", mem_addr, fault); end
        @(negedge clk);
        rst = 1'b0;
        step();
        total++; if (mem_addr !== 32'h0) begin bad++; $display("[TB] FAIL arst_restart got=%h exp=0", mem_addr); end
        step();
        step();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'h0) begin bad++; $display("[TB] FAIL arst_first valid=%0b pc=%h inst=%h", out_valid, out_pc, out_inst); end
    endtask

    // Run all scenarios in sequence, then report.
    initial begin
        rst            = 1'b1;
        fetch_en       = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_misalign();
        test_fetch_en();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
